// File: rtl/fit_result_packer.sv
// fit_result_packer
//   Captures track-fit results, applies a chi-sum cut, queues surviving
//   records in a small buffer and streams each one downstream as four
//   36-bit words. Word bits [35:34] carry the word index (0..3).
//
// Ports
//   i_clock            single clock, rising edge
//   i_reset            synchronous, active-low reset
//   i_fit_ready        one-cycle strobe; all result inputs valid this cycle
//   i_parameters       {phi, c, d}
//   i_chi1_in..3_in    unsigned chi components
//   i_hits1..5         SVX hits;  i_hits6  XFT hit
//   i_hitmap, i_lcmap  5-bit maps
//   i_fit_overflow, i_chi_overflow   fit status flags
//   i_chi_cut          chi-sum threshold (quasi-static)
//   i_out_full         downstream FIFO full
//   o_out_data         output word, qualified by o_out_wr
//   o_out_wr           write strobe to downstream FIFO
//   o_busy             buffer non-empty or a record is being emitted
//   o_n_written        records fully emitted (saturating)
//   o_n_chi_fail       records failing the chi cut (saturating)
//   o_n_lost           records lost to a full buffer (saturating)
//   o_lost_flag        sticky: at least one record lost
//
// The word layout assumes the default field widths.
module fit_result_packer #(
  parameter int PHIWIDTH     = 14,
  parameter int CWIDTH       = 10,
  parameter int DWIDTH       = 11,
  parameter int CHIWIDTH     = 15,
  parameter int HITBITS_SVX  = 8,
  parameter int HITBITS_XFT  = 13,
  parameter int DEPTH        = 4,
  parameter bit DROP_FAILED  = 1'b1
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_fit_ready,
  input  logic [PHIWIDTH+CWIDTH+DWIDTH-1:0]  i_parameters,
  input  logic [CHIWIDTH-1:0]                i_chi1_in,
  input  logic [CHIWIDTH-1:0]                i_chi2_in,
  input  logic [CHIWIDTH-1:0]                i_chi3_in,
  input  logic [HITBITS_SVX-1:0]             i_hits1,
  input  logic [HITBITS_SVX-1:0]             i_hits2,
  input  logic [HITBITS_SVX-1:0]             i_hits3,
  input  logic [HITBITS_SVX-1:0]             i_hits4,
  input  logic [HITBITS_SVX-1:0]             i_hits5,
  input  logic [HITBITS_XFT-1:0]             i_hits6,
  input  logic [4:0]                         i_hitmap,
  input  logic [4:0]                         i_lcmap,
  input  logic                               i_fit_overflow,
  input  logic                               i_chi_overflow,
  input  logic [CHIWIDTH+1:0]                i_chi_cut,
  input  logic                               i_out_full,
  output logic [35:0]                        o_out_data,
  output logic                               o_out_wr,
  output logic                               o_busy,
  output logic [15:0]                        o_n_written,
  output logic [15:0]                        o_n_chi_fail,
  output logic [15:0]                        o_n_lost,
  output logic                               o_lost_flag
);

  localparam int PW = PHIWIDTH + CWIDTH + DWIDTH;
  localparam int SW = CHIWIDTH + 2;
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]             hitmap;
    logic [4:0]             lcmap;
    logic                   fit_ov;
    logic                   chi_ov;
    logic                   fail;
    logic [SW-1:0]          chisum;
    logic [PW-1:0]          params;
    logic [HITBITS_XFT-1:0] hits6;
    logic [HITBITS_SVX-1:0] hits5;
    logic [HITBITS_SVX-1:0] hits4;
    logic [HITBITS_SVX-1:0] hits3;
    logic [HITBITS_SVX-1:0] hits2;
    logic [HITBITS_SVX-1:0] hits1;
  } rec_t;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- capture ----------------
  logic [SW-1:0] w_chisum;
  logic          w_fail;
  logic          w_keep;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_lost;
  logic          w_pop;
  rec_t          w_rec;

  state_t        r_state;
  state_t        w_state_nxt;
  rec_t          r_buf [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  rec_t          r_emit;
  logic [35:0]   r_last_data;
  logic [15:0]   r_n_written;
  logic [15:0]   r_n_chi_fail;
  logic [15:0]   r_n_lost;
  logic          r_lost_flag;
  logic          w_wr;
  logic [35:0]   w_word;

  assign w_chisum = {2'b00, i_chi1_in} + {2'b00, i_chi2_in} + {2'b00, i_chi3_in};
  assign w_fail   = (w_chisum > i_chi_cut);
  assign w_keep   = i_fit_ready && (!w_fail || (DROP_FAILED == 1'b0));
  // Full uses the pre-read occupancy: a same-cycle pop does not make room.
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = w_keep && !w_full;
  assign w_lost   = w_keep && w_full;

  // A record only leaves the buffer when its first word can actually go out
  // (IDLE with downstream ready, or chaining straight out of a W3 write), so
  // a stalled downstream leaves exactly DEPTH records of capacity.
  assign w_pop = ((r_state == S_IDLE) && !w_empty && !i_out_full) ||
                 ((r_state == S_W3) && w_wr && !w_empty);

  always_comb begin
    w_rec        = '0;
    w_rec.hitmap = i_hitmap;
    w_rec.lcmap  = i_lcmap;
    w_rec.fit_ov = i_fit_overflow;
    w_rec.chi_ov = i_chi_overflow;
    w_rec.fail   = w_fail;
    w_rec.chisum = w_chisum;
    w_rec.params = i_parameters;
    w_rec.hits6  = i_hits6;
    w_rec.hits5  = i_hits5;
    w_rec.hits4  = i_hits4;
    w_rec.hits3  = i_hits3;
    w_rec.hits2  = i_hits2;
    w_rec.hits1  = i_hits1;
  end

  // ---------------- record buffer ----------------
  always_ff @(posedge i_clock) begin
    if (w_push) r_buf[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset)   r_emit <= '0;
    else if (w_pop) r_emit <= r_buf[r_rd_ptr];
  end

  // ---------------- emitter FSM ----------------
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty && !i_out_full) w_state_nxt = S_W0;
      S_W0:   if (!i_out_full) w_state_nxt = S_W1;
      S_W1:   if (!i_out_full) w_state_nxt = S_W2;
      S_W2:   if (!i_out_full) w_state_nxt = S_W3;
      S_W3:   if (!i_out_full) w_state_nxt = w_empty ? S_IDLE : S_W0;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr   = 1'b0;
    w_word = '0;
    case (r_state)
      S_W0: begin
        w_wr   = !i_out_full;
        w_word = {2'd0, r_emit.hitmap, r_emit.lcmap, r_emit.fit_ov,
                  r_emit.chi_ov, r_emit.fail, 4'b0000, r_emit.chisum};
      end
      S_W1: begin
        w_wr   = !i_out_full;
        w_word = {2'd1, r_emit.params[PW-1:DWIDTH], 10'b0};
      end
      S_W2: begin
        w_wr   = !i_out_full;
        w_word = {2'd2, 2'b00, r_emit.params[DWIDTH-1:0], r_emit.hits6, r_emit.hits5};
      end
      S_W3: begin
        w_wr   = !i_out_full;
        w_word = {2'd3, 2'b00, r_emit.hits4, r_emit.hits3, r_emit.hits2, r_emit.hits1};
      end
      default: ;
    endcase
  end

  // out_data keeps showing the last word written while the strobe is low.
  always_ff @(posedge i_clock) begin
    if (!i_reset)  r_last_data <= '0;
    else if (w_wr) r_last_data <= w_word;
  end

  // ---------------- statistics ----------------
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_n_written  <= '0;
      r_n_chi_fail <= '0;
      r_n_lost     <= '0;
      r_lost_flag  <= 1'b0;
    end else begin
      if ((r_state == S_W3) && w_wr) r_n_written  <= sat_inc(r_n_written);
      if (i_fit_ready && w_fail)     r_n_chi_fail <= sat_inc(r_n_chi_fail);
      if (w_lost) begin
        r_n_lost    <= sat_inc(r_n_lost);
        r_lost_flag <= 1'b1;
      end
    end
  end

  assign o_out_wr     = w_wr;
  assign o_out_data   = w_wr ? w_word : r_last_data;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;
  assign o_n_written  = r_n_written;
  assign o_n_chi_fail = r_n_chi_fail;
  assign o_n_lost     = r_n_lost;
  assign o_lost_flag  = r_lost_flag;

endmodule

// File: tb/tb_fit_result_packer.sv
module tb_fit_result_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fit;
  logic [34:0] par;
  logic [14:0] c1, c2, c3;
  logic [7:0]  h1, h2, h3, h4, h5;
  logic [12:0] h6;
  logic [4:0]  hm, lc;
  logic        fov, cov;
  logic [16:0] cut;
  logic        full;

  logic [35:0] data_a, data_b;
  logic        wr_a, wr_b, busy_a, busy_b, lf_a, lf_b;
  logic [15:0] nw_a, ncf_a, nl_a, nw_b, ncf_b, nl_b;

  fit_result_packer #(.DROP_FAILED(1'b1)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_fit_ready(fit), .i_parameters(par),
    .i_chi1_in(c1), .i_chi2_in(c2), .i_chi3_in(c3),
    .i_hits1(h1), .i_hits2(h2), .i_hits3(h3), .i_hits4(h4), .i_hits5(h5), .i_hits6(h6),
    .i_hitmap(hm), .i_lcmap(lc), .i_fit_overflow(fov), .i_chi_overflow(cov),
    .i_chi_cut(cut), .i_out_full(full),
    .o_out_data(data_a), .o_out_wr(wr_a), .o_busy(busy_a),
    .o_n_written(nw_a), .o_n_chi_fail(ncf_a), .o_n_lost(nl_a), .o_lost_flag(lf_a));

  fit_result_packer #(.DROP_FAILED(1'b0)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_fit_ready(fit), .i_parameters(par),
    .i_chi1_in(c1), .i_chi2_in(c2), .i_chi3_in(c3),
    .i_hits1(h1), .i_hits2(h2), .i_hits3(h3), .i_hits4(h4), .i_hits5(h5), .i_hits6(h6),
    .i_hitmap(hm), .i_lcmap(lc), .i_fit_overflow(fov), .i_chi_overflow(cov),
    .i_chi_cut(cut), .i_out_full(full),
    .o_out_data(data_b), .o_out_wr(wr_b), .o_busy(busy_b),
    .o_n_written(nw_b), .o_n_chi_fail(ncf_b), .o_n_lost(nl_b), .o_lost_flag(lf_b));

  typedef struct {
    int          cyc;
    logic [35:0] d;
  } wd_t;

  typedef struct packed {
    logic [14:0] c1, c2, c3;
    logic [34:0] par;
    logic [7:0]  h1, h2, h3, h4, h5;
    logic [12:0] h6;
    logic [4:0]  hm, lc;
    logic        fo, co;
  } trk_t;

  typedef struct {
    logic [14:0] a, b, c;
    logic [16:0] cut;
    logic [16:0] sum;
    logic        fail;
  } vec_t;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  wd_t qa[$];
  wd_t qb[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_a) qa.push_back('{cyc, data_a});
    if (wr_b) qb.push_back('{cyc, data_b});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic trk_t mk(input int k, input logic [14:0] a, input logic [14:0] b,
                              input logic [14:0] c);
    trk_t t;
    t.c1  = a; t.c2 = b; t.c3 = c;
    t.par = 35'(k) * 35'h0_9E37_79B1 + 35'h5_0A0F_1234;
    t.h1  = 8'(k + 8'h11); t.h2 = 8'(k * 3 + 8'h22);
    t.h3  = 8'(k * 5 + 8'h33); t.h4 = 8'(k * 7 + 8'h44);
    t.h5  = 8'(k * 11 + 8'h55); t.h6 = 13'(k * 97 + 13'h1ABC);
    t.hm  = 5'(k); t.lc = 5'(~k);
    t.fo  = k[0]; t.co = k[1];
    return t;
  endfunction

  // Expected output word from the documented layout.
  function automatic logic [35:0] ew(input trk_t t, input logic [16:0] s, input logic f,
                                     input int w);
    case (w)
      0:       return {2'd0, t.hm, t.lc, t.fo, t.co, f, 4'b0000, s};
      1:       return {2'd1, t.par[34:11], 10'b0};
      2:       return {2'd2, 2'b00, t.par[10:0], t.h6, t.h5};
      default: return {2'd3, 2'b00, t.h4, t.h3, t.h2, t.h1};
    endcase
  endfunction

  task automatic apply(input trk_t t);
    c1 = t.c1; c2 = t.c2; c3 = t.c3; par = t.par;
    h1 = t.h1; h2 = t.h2; h3 = t.h3; h4 = t.h4; h5 = t.h5; h6 = t.h6;
    hm = t.hm; lc = t.lc; fov = t.fo; cov = t.co;
  endtask

  task automatic fire(input trk_t t);
    apply(t);
    fit = 1'b1;
    step();
    fit = 1'b0;
  endtask

  vec_t  vt[6];
  trk_t  t, tl;
  trk_t  tk[6];
  int    f0;
  int    nc0, nl0, nw0;

  initial begin
    vt[0] = '{15'd100,   15'd200,   15'd300,   17'd1000,    17'd600,   1'b0};
    vt[1] = '{15'd10000, 15'd10000, 15'd10000, 17'd1000,    17'd30000, 1'b1};
    vt[2] = '{15'd32767, 15'd32767, 15'd32767, 17'h1FFFF,   17'd98301, 1'b0};
    vt[3] = '{15'd500,   15'd500,   15'd0,     17'd1000,    17'd1000,  1'b0};
    vt[4] = '{15'd500,   15'd500,   15'd1,     17'd1000,    17'd1001,  1'b1};
    vt[5] = '{15'd0,     15'd0,     15'd0,     17'd0,       17'd0,     1'b0};

    rst_n = 1'b0; fit = 1'b0; full = 1'b0; cut = 17'd1000;
    apply(mk(0, 15'd1, 15'd2, 15'd3));

    // fit_ready asserted while in reset must be ignored
    step();
    fit = 1'b1;
    repeat (3) step();
    fit = 1'b0;
    chk("rst_wr",    64'(wr_a),   64'd0);
    chk("rst_data",  64'(data_a), 64'd0);
    chk("rst_busy",  64'(busy_a), 64'd0);
    chk("rst_nw",    64'(nw_a),   64'd0);
    chk("rst_ncf",   64'(ncf_a),  64'd0);
    chk("rst_nl",    64'(nl_a),   64'd0);
    chk("rst_lf",    64'(lf_a),   64'd0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_fit_ignored_words", 64'(qa.size()), 64'd0);
    chk("rst_fit_ignored_busy",  64'(busy_a),    64'd0);

    // table-driven single tracks
    for (int i = 0; i < 6; i++) begin
      t   = mk(i + 1, vt[i].a, vt[i].b, vt[i].c);
      cut = vt[i].cut;
      qa.delete(); qb.delete();
      nc0 = int'(ncf_a);
      f0  = cyc;
      fire(t);
      repeat (8) step();
      chk($sformatf("v%0d_cnt_a", i), 64'(qa.size()), vt[i].fail ? 64'd0 : 64'd4);
      chk($sformatf("v%0d_cnt_b", i), 64'(qb.size()), 64'd4);
      for (int w = 0; w < qa.size() && w < 4; w++) begin
        chk($sformatf("v%0d_a_cyc%0d", i, w), 64'(qa[w].cyc), 64'(f0 + 2 + w));
        chk($sformatf("v%0d_a_w%0d", i, w), 64'(qa[w].d), 64'(ew(t, vt[i].sum, vt[i].fail, w)));
      end
      for (int w = 0; w < qb.size() && w < 4; w++)
        chk($sformatf("v%0d_b_w%0d", i, w), 64'(qb[w].d), 64'(ew(t, vt[i].sum, vt[i].fail, w)));
      chk($sformatf("v%0d_chifail", i), 64'(int'(ncf_a) - nc0), 64'(vt[i].fail));
      chk($sformatf("v%0d_idle", i), 64'(busy_a), 64'd0);
      if (i == 0) chk("v0_nwritten", 64'(nw_a), 64'd1);
      if (!vt[i].fail) tl = t;
    end
    // out_data holds the last word while idle
    chk("hold_data", 64'(data_a), 64'(ew(tl, 17'd0, 1'b0, 3)));
    chk("hold_wr",   64'(wr_a),   64'd0);

    // backpressure for 5 cycles in the middle of W1
    cut = 17'd1000;
    t   = mk(20, 15'd100, 15'd200, 15'd300);
    qa.delete();
    f0  = cyc;
    fire(t);
    step();
    step();
    full = 1'b1;
    repeat (5) step();
    full = 1'b0;
    repeat (6) step();
    chk("bp_cnt", 64'(qa.size()), 64'd4);
    for (int w = 0; w < qa.size() && w < 4; w++) begin
      chk($sformatf("bp_w%0d", w), 64'(qa[w].d), 64'(ew(t, 17'd600, 1'b0, w)));
      chk($sformatf("bp_cyc%0d", w), 64'(qa[w].cyc), (w == 0) ? 64'(f0 + 2) : 64'(f0 + 7 + w));
    end

    // buffer overflow: 6 strobes while downstream is full
    nl0 = int'(nl_a); nw0 = int'(nw_a);
    qa.delete();
    full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tk[k] = mk(30 + k, 15'd1, 15'd2, 15'd3);
      fire(tk[k]);
    end
    step();
    chk("ovf_nlost", 64'(int'(nl_a) - nl0), 64'd2);
    chk("ovf_flag",  64'(lf_a),   64'd1);
    chk("ovf_quiet", 64'(qa.size()), 64'd0);
    chk("ovf_busy",  64'(busy_a), 64'd1);
    full = 1'b0;
    repeat (24) step();
    chk("ovf_cnt", 64'(qa.size()), 64'd16);
    for (int i = 0; i < qa.size() && i < 16; i++) begin
      chk($sformatf("ovf_w%0d", i), 64'(qa[i].d), 64'(ew(tk[i / 4], 17'd6, 1'b0, i % 4)));
      chk($sformatf("ovf_cyc%0d", i), 64'(qa[i].cyc), 64'(qa[0].cyc + i));
    end
    chk("ovf_nwritten", 64'(int'(nw_a) - nw0), 64'd4);

    // back-to-back tracks every 4 cycles, no gap
    qa.delete();
    f0 = cyc;
    for (int k = 0; k < 4; k++) begin
      tk[k] = mk(50 + k, 15'd7, 15'd8, 15'd9);
      fire(tk[k]);
      repeat (3) step();
    end
    repeat (8) step();
    chk("b2b_cnt", 64'(qa.size()), 64'd16);
    for (int i = 0; i < qa.size() && i < 16; i++) begin
      chk($sformatf("b2b_cyc%0d", i), 64'(qa[i].cyc), 64'(f0 + 2 + i));
      chk($sformatf("b2b_w%0d", i), 64'(qa[i].d), 64'(ew(tk[i / 4], 17'd24, 1'b0, i % 4)));
    end

    // reset during W2 abandons the record
    t  = mk(70, 15'd5, 15'd5, 15'd5);
    qa.delete();
    f0 = cyc;
    fire(t);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("mrst_wr",   64'(wr_a),   64'd0);
    chk("mrst_busy", 64'(busy_a), 64'd0);
    chk("mrst_data", 64'(data_a), 64'd0);
    chk("mrst_nw",   64'(nw_a),   64'd0);
    chk("mrst_ncf",  64'(ncf_a),  64'd0);
    chk("mrst_nl",   64'(nl_a),   64'd0);
    chk("mrst_lf",   64'(lf_a),   64'd0);
    rst_n = 1'b1;
    qa.delete();
    repeat (4) step();
    chk("mrst_abandon", 64'(qa.size()), 64'd0);
    t  = mk(71, 15'd1, 15'd1, 15'd1);
    f0 = cyc;
    fire(t);
    repeat (8) step();
    chk("mrst_new_cnt", 64'(qa.size()), 64'd4);
    for (int w = 0; w < qa.size() && w < 4; w++) begin
      chk($sformatf("mrst_new_cyc%0d", w), 64'(qa[w].cyc), 64'(f0 + 2 + w));
      chk($sformatf("mrst_new_w%0d", w), 64'(qa[w].d), 64'(ew(t, 17'd3, 1'b0, w)));
    end
    chk("mrst_new_nw", 64'(nw_a), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
